clause_dispatch_buffer: RTL and testbench

- Parametrised successor to the single-load clause buffer.
- Accepts the serial clause-node stream and per-engine dummy pointers from the memory loader, and distributes them into NUM_ENG per-engine FIFOs.
- Supports two engine-selection modes: sequential (advance on change_eng) or round-robin per node.
- Each engine drains its FIFO with a valid/ready handshake.

---
 rtl/clause_dispatch_buffer.sv | 107 ++++++++++
 tb/tb_clause_dispatch_buffer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/clause_dispatch_buffer.sv
// clause_dispatch_buffer: distributes the serial clause-node stream into per-engine show-ahead FIFOs
// and latches per-engine dummy pointers, with sequential or round-robin engine selection.
module clause_dispatch_buffer #(
  parameter int NUM_ENG = 4,
  parameter int NODE_W  = 64,
  parameter int PTR_W   = 16,
  parameter int DEPTH   = 8,
  parameter int MODE_RR = 0,
  localparam int EW = (NUM_ENG > 1) ? $clog2(NUM_ENG) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       restart,
  input  logic [NODE_W-1:0]          node_in,
  input  logic                       node_in_valid,
  output logic                       node_in_ready,
  input  logic [PTR_W-1:0]           ptr_in,
  input  logic                       ptr_in_valid,
  input  logic                       change_eng,
  output logic [NUM_ENG*NODE_W-1:0]  node_out,
  output logic [NUM_ENG-1:0]         node_out_valid,
  input  logic [NUM_ENG-1:0]         node_out_ready,
  output logic [NUM_ENG*PTR_W-1:0]   ptr_out,
  output logic [NUM_ENG-1:0]         ptr_valid_out,
  output logic [EW-1:0]              cur_eng,
  output logic                       load_done,
  output logic                       overflow_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  typedef enum logic {LOAD, DONE} state_t;
  state_t state;
  logic [EW-1:0] tgt, nxt;
  logic [NUM_ENG-1:0] full;
  logic push, last;
  assign node_in_ready = (state == LOAD) & ~full[tgt];
  assign push = node_in_valid & node_in_ready & ~restart;
  assign last = tgt == EW'(NUM_ENG - 1);
  assign nxt = last ? '0 : tgt + 1'b1;
  assign cur_eng = tgt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= LOAD;
      tgt <= '0;
      load_done <= 1'b0;
      overflow_err <= 1'b0;
    end else if (restart) begin
      state <= LOAD;
      tgt <= '0;
      load_done <= 1'b0;
      overflow_err <= 1'b0;
    end else if (state == LOAD) begin
      if (MODE_RR != 0) begin
        if (push) tgt <= nxt;
        if (change_eng) begin
          state <= DONE;
          load_done <= 1'b1;
        end
      end else if (change_eng) begin
        if (last) begin
          state <= DONE;
          load_done <= 1'b1;
        end else tgt <= nxt;
      end
    end else if (change_eng) overflow_err <= 1'b1;
  end
  for (genvar i = 0; i < NUM_ENG; i++) begin : g_eng
    logic [NODE_W-1:0] mem [DEPTH];
    logic [AW-1:0] rd, wr;
    logic [CW-1:0] cnt;
    logic [PTR_W-1:0] ptr;
    logic pv, sel, wr_en, rd_en;
    assign sel = tgt == EW'(i);
    assign wr_en = push & sel;
    assign rd_en = node_out_valid[i] & node_out_ready[i];
    assign full[i] = cnt == CW'(DEPTH);
    assign node_out_valid[i] = cnt != '0;
    assign node_out[i*NODE_W +: NODE_W] = mem[rd];
    assign ptr_out[i*PTR_W +: PTR_W] = ptr;
    assign ptr_valid_out[i] = pv;
    // storage carries no reset: contents are ignored while the count is zero
    always_ff @(posedge clk) if (wr_en) mem[wr] <= node_in;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rd <= '0;
        wr <= '0;
        cnt <= '0;
        ptr <= '0;
        pv <= 1'b0;
      end else if (restart) begin
        rd <= '0;
        wr <= '0;
        cnt <= '0;
        ptr <= '0;
        pv <= 1'b0;
      end else begin
        if (wr_en) wr <= wr + 1'b1;
        if (rd_en) rd <= rd + 1'b1;
        cnt <= cnt + CW'(wr_en) - CW'(rd_en);
        if (ptr_in_valid & sel) begin
          ptr <= ptr_in;
          pv <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_clause_dispatch_buffer.sv
// tb_clause_dispatch_buffer: directed stimulus with per-engine expected-node queues checked by a monitor,
// covering a sequential-mode and a round-robin instance.
module tb_clause_dispatch_buffer;
  localparam int NE = 4, NW = 16, PW = 16, DP = 4;
  logic clk = 0, rst_n = 0, restart = 0;
  logic [NW-1:0] node_in = '0;
  logic node_in_valid = 0, ptr_in_valid = 0, change_eng = 0;
  logic [PW-1:0] ptr_in = '0;
  logic [NE-1:0] node_out_ready = '0;
  logic [NE*NW-1:0] s_node_out, r_node_out, m_node_out;
  logic [NE-1:0] s_valid, r_valid, m_valid, s_pv, r_pv;
  logic [NE*PW-1:0] s_ptr, r_ptr;
  logic [1:0] s_cur, r_cur, m_cur;
  logic s_ready, r_ready, m_ready, s_done, r_done, s_ovf, r_ovf;
  logic rr_phase = 0;
  int compared = 0, mismatched = 0;
  logic [NW-1:0] exp_q [NE][$];

  always #5 clk = ~clk;

  clause_dispatch_buffer #(.NUM_ENG(NE), .NODE_W(NW), .PTR_W(PW), .DEPTH(DP), .MODE_RR(0)) u_seq (
    .clk(clk), .rst_n(rst_n), .restart(restart), .node_in(node_in), .node_in_valid(node_in_valid),
    .node_in_ready(s_ready), .ptr_in(ptr_in), .ptr_in_valid(ptr_in_valid), .change_eng(change_eng),
    .node_out(s_node_out), .node_out_valid(s_valid), .node_out_ready(node_out_ready), .ptr_out(s_ptr),
    .ptr_valid_out(s_pv), .cur_eng(s_cur), .load_done(s_done), .overflow_err(s_ovf));

  clause_dispatch_buffer #(.NUM_ENG(NE), .NODE_W(NW), .PTR_W(PW), .DEPTH(DP), .MODE_RR(1)) u_rr (
    .clk(clk), .rst_n(rst_n), .restart(restart), .node_in(node_in), .node_in_valid(node_in_valid),
    .node_in_ready(r_ready), .ptr_in(ptr_in), .ptr_in_valid(ptr_in_valid), .change_eng(change_eng),
    .node_out(r_node_out), .node_out_valid(r_valid), .node_out_ready(node_out_ready), .ptr_out(r_ptr),
    .ptr_valid_out(r_pv), .cur_eng(r_cur), .load_done(r_done), .overflow_err(r_ovf));

  assign m_node_out = rr_phase ? r_node_out : s_node_out;
  assign m_valid = rr_phase ? r_valid : s_valid;
  assign m_ready = rr_phase ? r_ready : s_ready;
  assign m_cur = rr_phase ? r_cur : s_cur;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic sample;
    @(negedge clk);
  endtask

  // offer one node and wait (bounded) for the active DUT to take it
  task automatic push_node(input int eng, input logic [NW-1:0] d);
    bit ok = 0;
    node_in = d;
    node_in_valid = 1;
    for (int k = 0; k < 20 && !ok; k++) begin
      sample;
      if (m_ready) ok = 1;
      else tick;
    end
    if (ok) exp_q[eng].push_back(d);
    else check("push_timeout", 0, 1);
    tick;
    node_in_valid = 0;
  endtask

  task automatic pulse_change;
    change_eng = 1;
    tick;
    change_eng = 0;
  endtask

  task automatic do_restart;
    restart = 1;
    tick;
    restart = 0;
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < NE; i++)
      if (m_valid[i] && node_out_ready[i]) begin
        if (exp_q[i].size() == 0) check($sformatf("unexpected_pop%0d", i), m_node_out[i*NW +: NW], 64'hDEAD);
        else check($sformatf("pop_eng%0d", i), m_node_out[i*NW +: NW], exp_q[i].pop_front());
      end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tick;
    tick;
    sample;
    check("rst_valid", s_valid, 0);
    check("rst_ptr_valid", s_pv, 0);
    check("rst_load_done", s_done, 0);
    check("rst_overflow", s_ovf, 0);
    check("rst_cur_eng", s_cur, 0);
    check("rst_ready", s_ready, 1);
    tick;
    rst_n = 1;
    // sequential distribution
    push_node(0, 16'h000A);
    push_node(0, 16'h000B);
    push_node(0, 16'h000C);
    pulse_change;
    push_node(1, 16'h000D);
    sample;
    check("seq_valid", s_valid, 4'b0011);
    check("seq_cur_eng", s_cur, 1);
    check("seq_head0", s_node_out[0 +: NW], 16'h000A);
    tick;
    node_out_ready = 4'b0001;
    repeat (3) tick;
    node_out_ready = 4'b0000;
    sample;
    check("seq_drained0", s_valid, 4'b0010);
    tick;
    node_out_ready = 4'b0010;
    tick;
    node_out_ready = 4'b0000;
    // full FIFO, held node, no bypass
    do_restart;
    sample;
    check("restart_cur", s_cur, 0);
    tick;
    for (int k = 0; k < 4; k++) push_node(0, NW'(16'h0011 + k));
    node_in = 16'h000E;
    node_in_valid = 1;
    sample;
    check("full_ready", s_ready, 0);
    tick;
    sample;
    check("full_held", s_ready, 0);
    tick;
    node_out_ready = 4'b0001;
    sample;
    check("full_no_bypass", s_ready, 0);
    tick;
    node_out_ready = 4'b0000;
    sample;
    check("full_after_pop", s_ready, 1);
    exp_q[0].push_back(16'h000E);
    tick;
    node_in_valid = 0;
    node_out_ready = 4'b0001;
    repeat (4) tick;
    node_out_ready = 4'b0000;
    sample;
    check("full_drained", s_valid, 0);
    tick;
    // pointer load coincident with change_eng, then DONE behaviour
    do_restart;
    pulse_change;
    pulse_change;
    ptr_in = 16'h0012;
    ptr_in_valid = 1;
    change_eng = 1;
    tick;
    ptr_in_valid = 0;
    change_eng = 0;
    sample;
    check("ptr2_value", s_ptr[2*PW +: PW], 16'h0012);
    check("ptr_valid_vec", s_pv, 4'b0100);
    check("ptr_cur_eng", s_cur, 3);
    tick;
    pulse_change;
    sample;
    check("done_flag", s_done, 1);
    check("done_ready", s_ready, 0);
    check("done_cur_eng", s_cur, 3);
    check("done_no_ovf", s_ovf, 0);
    tick;
    ptr_in = 16'h0033;
    ptr_in_valid = 1;
    tick;
    ptr_in = 16'h0044;
    tick;
    ptr_in_valid = 0;
    sample;
    check("ptr3_overwrite", s_ptr[3*PW +: PW], 16'h0044);
    check("ptr_valid_vec2", s_pv, 4'b1100);
    tick;
    pulse_change;
    sample;
    check("overflow_set", s_ovf, 1);
    tick;
    tick;
    sample;
    check("overflow_sticky", s_ovf, 1);
    tick;
    do_restart;
    sample;
    check("rs_valid", s_valid, 0);
    check("rs_ptr_valid", s_pv, 0);
    check("rs_ptr_out", s_ptr, 0);
    check("rs_done", s_done, 0);
    check("rs_ovf", s_ovf, 0);
    check("rs_cur", s_cur, 0);
    check("rs_ready", s_ready, 1);
    tick;
    // restart drops a node offered in the same cycle
    node_in = 16'h0077;
    node_in_valid = 1;
    restart = 1;
    tick;
    restart = 0;
    node_in_valid = 0;
    sample;
    check("restart_drop", s_valid, 0);
    tick;
    // asynchronous reset with nodes queued
    push_node(0, 16'h0021);
    push_node(0, 16'h0022);
    sample;
    check("pre_reset_valid", s_valid, 4'b0001);
    tick;
    rst_n = 0;
    #2;
    check("async_reset_valid", s_valid, 0);
    exp_q[0].delete();
    tick;
    rst_n = 1;
    sample;
    check("post_reset_ready", s_ready, 1);
    check("post_reset_cur", s_cur, 0);
    tick;
    // round-robin instance
    rr_phase = 1;
    do_restart;
    for (int k = 0; k < 8; k++) push_node(k % NE, NW'(k));
    sample;
    check("rr_cur_eng", r_cur, 0);
    check("rr_valid", r_valid, 4'b1111);
    tick;
    node_out_ready = 4'b1111;
    repeat (2) tick;
    node_out_ready = 4'b0000;
    sample;
    check("rr_drained", r_valid, 0);
    tick;
    pulse_change;
    sample;
    check("rr_done", r_done, 1);
    check("rr_done_ready", r_ready, 0);
    for (int i = 0; i < NE; i++) check($sformatf("queue_empty%0d", i), exp_q[i].size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
